// File: rtl/mem_port_arbiter_if.sv
// Pipeline- and memory-facing signals of the shared memory port arbiter.
// master is the arbiter's view; slave is the view of the pipeline/memory around it.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;

  logic          stall_fetch;
  logic          stall_mem;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          timeout_err;
  logic [15:0]   conflict_cnt;

  modport master (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, dm_rdata, dm_done, stall_fetch, stall_mem,
    output mem_addr, mem_wdata, mem_rd, mem_wr, timeout_err, conflict_cnt
  );

  modport slave (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, dm_rdata, dm_done, stall_fetch, stall_mem,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, timeout_err, conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between instruction fetch and data accesses.
// Data has priority; each access ends on mem_ready or after TIMEOUT wait cycles.
module mem_port_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  localparam logic [7:0] WaitLimit = 8'(TIMEOUT - 1);

  state_e        state_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          if_valid_q;
  logic          dm_done_q;
  logic          timeout_err_q;
  logic [7:0]    wait_cnt_q;
  logic [15:0]   conflict_cnt_q;

  logic busy;
  logic at_limit;
  logic complete;
  logic timed_out;
  logic arb_en;
  logic dm_pend;
  logic if_pend;

  always_comb begin
    busy      = (state_q != StIdle);
    at_limit  = (wait_cnt_q == WaitLimit);
    complete  = busy & (bus_io.mem_ready | at_limit);
    timed_out = busy & ~bus_io.mem_ready & at_limit;
    arb_en    = ~busy | complete;
    // A requester being completed now, or pulsed now, is still holding its old request.
    dm_pend   = (bus_io.dm_rd | bus_io.dm_wr) & ~dm_done_q & ~(complete & (state_q == StData));
    if_pend   = bus_io.if_req & ~if_valid_q & ~(complete & (state_q == StFetch));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      if_rdata_q     <= '0;
      dm_rdata_q     <= '0;
      if_valid_q     <= 1'b0;
      dm_done_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      wait_cnt_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_done_q  <= 1'b0;

      if (busy && !complete) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end

      if (complete) begin
        if (state_q == StFetch) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= timed_out ? '1 : bus_io.mem_rdata;
        end else begin
          dm_done_q <= 1'b1;
          if (!mem_wr_q) begin
            dm_rdata_q <= timed_out ? '1 : bus_io.mem_rdata;
          end
        end
        if (timed_out) begin
          timeout_err_q <= 1'b1;
        end
      end

      if (arb_en) begin
        wait_cnt_q <= '0;
        if (dm_pend) begin
          // Read and write together is treated as a write.
          state_q     <= StData;
          mem_addr_q  <= bus_io.dm_addr;
          mem_rd_q    <= ~bus_io.dm_wr;
          mem_wr_q    <= bus_io.dm_wr;
          mem_wdata_q <= bus_io.dm_wr ? bus_io.dm_wdata : '0;
        end else if (if_pend) begin
          state_q     <= StFetch;
          mem_addr_q  <= bus_io.if_addr;
          mem_rd_q    <= 1'b1;
          mem_wr_q    <= 1'b0;
          mem_wdata_q <= '0;
        end else begin
          state_q     <= StIdle;
          mem_addr_q  <= '0;
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_wdata_q <= '0;
        end
      end

      if (bus_io.if_req && (state_q == StData) && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
    end
  end

  assign bus_io.mem_addr     = mem_addr_q;
  assign bus_io.mem_wdata    = mem_wdata_q;
  assign bus_io.mem_rd       = mem_rd_q;
  assign bus_io.mem_wr       = mem_wr_q;
  assign bus_io.if_rdata     = if_rdata_q;
  assign bus_io.dm_rdata     = dm_rdata_q;
  assign bus_io.if_valid     = if_valid_q;
  assign bus_io.dm_done      = dm_done_q;
  assign bus_io.timeout_err  = timeout_err_q;
  assign bus_io.conflict_cnt = conflict_cnt_q;
  assign bus_io.stall_fetch  = bus_io.if_req & ~if_valid_q;
  assign bus_io.stall_mem    = (bus_io.dm_rd | bus_io.dm_wr) & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic against a latency-by-address
// memory, plus directed timing scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  typedef struct packed {
    logic [15:0] rdata;
    logic        to;
  } resp_t;

  resp_t       if_q[$];
  resp_t       dm_q[$];
  int          n_checks = 0;
  int          n_errs = 0;
  logic        exp_err = 1'b0;
  logic [15:0] cur_dm_addr = '0;
  logic [15:0] cur_dm_wdata = '0;
  logic [15:0] last_dm = '0;
  int          force_lat = -1;
  logic        force_en = 1'b0;
  logic [15:0] force_val = '0;
  int          mem_w;
  int          mem_lat;
  logic [14:0] vbits, rbits, wbits, dbits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory contents and latency are fixed functions of the address.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hC3A5;
  endfunction

  function automatic logic is_to(input logic [15:0] a);
    return int'(a[2:0]) >= int'(TO);
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if ($urandom_range(0, 3) != 0) a[2] = 1'b0;
    return a;
  endfunction

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_if(input logic [15:0] d, input logic to);
    resp_t r;
    r.rdata = d;
    r.to = to;
    if_q.push_back(r);
  endtask

  task automatic push_dm(input logic [15:0] d, input logic to);
    resp_t r;
    r.rdata = d;
    r.to = to;
    dm_q.push_back(r);
  endtask

  task automatic set_dm(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd);
    cur_dm_addr = a;
    cur_dm_wdata = wd;
    bus.dm_addr = a;
    bus.dm_wdata = wd;
    bus.dm_rd = rd;
    bus.dm_wr = wr;
  endtask

  task automatic wait_pulse(input logic is_dm, input string name);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = is_dm ? bus.dm_done : bus.if_valid;
    end
    if (!seen) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s: no completion pulse within 60 cycles", name);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.dm_rd = 1'b0;
    bus.dm_wr = 1'b0;
    force_en = 1'b0;
    force_lat = -1;
    repeat (2) next_cyc();
    if_q.delete();
    dm_q.delete();
    exp_err = 1'b0;
    last_dm = '0;
    reset = 1'b0;
  endtask

  task automatic run_fetch(input int n);
    for (int k = 0; k < n; k++) begin
      int          gap;
      logic [15:0] a;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        bus.if_req = 1'b0;
        repeat (gap) next_cyc();
      end
      a = rand_addr();
      push_if(is_to(a) ? 16'hFFFF : mem_val(a), is_to(a));
      bus.if_addr = a;
      bus.if_req = 1'b1;
      wait_pulse(1'b0, "random fetch");
      next_cyc();
    end
    bus.if_req = 1'b0;
  endtask

  task automatic run_data(input int n);
    for (int k = 0; k < n; k++) begin
      int          gap;
      logic [15:0] a;
      logic [15:0] wd;
      logic        rd;
      logic        wr;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        bus.dm_rd = 1'b0;
        bus.dm_wr = 1'b0;
        repeat (gap) next_cyc();
      end
      a = rand_addr();
      wd = 16'($urandom);
      case ($urandom_range(0, 4))
        0, 1:    begin rd = 1'b1; wr = 1'b0; end
        2, 3:    begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      if (!wr) last_dm = is_to(a) ? 16'hFFFF : mem_val(a);
      push_dm(last_dm, is_to(a));
      set_dm(rd, wr, a, wd);
      wait_pulse(1'b1, "random data");
      next_cyc();
    end
    bus.dm_rd = 1'b0;
    bus.dm_wr = 1'b0;
  endtask

  // Memory model: ready after the address-selected number of wait cycles.
  initial begin
    mem_w = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_rd || bus.mem_wr) begin
        mem_lat = (force_lat >= 0) ? force_lat : int'(bus.mem_addr[2:0]);
        bus.mem_ready = (mem_w == mem_lat);
        bus.mem_rdata = force_en ? force_val : mem_val(bus.mem_addr);
        if (mem_w == mem_lat || mem_w == int'(TO) - 1) mem_w = 0;
        else mem_w++;
      end else begin
        mem_w = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = 16'($urandom);
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.if_valid) begin
          if (if_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL if_valid: pulse with no outstanding fetch");
          end else begin
            e = if_q.pop_front();
            if (e.to) exp_err = 1'b1;
            check("if_rdata", bus.if_rdata, e.rdata);
            check("timeout_err at fetch pulse", bus.timeout_err, exp_err);
          end
        end
        if (bus.dm_done) begin
          if (dm_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL dm_done: pulse with no outstanding data access");
          end else begin
            e = dm_q.pop_front();
            if (e.to) exp_err = 1'b1;
            check("dm_rdata", bus.dm_rdata, e.rdata);
            check("timeout_err at data pulse", bus.timeout_err, exp_err);
          end
        end
        check("stall_fetch", bus.stall_fetch, bus.if_req & ~bus.if_valid);
        check("stall_mem", bus.stall_mem, (bus.dm_rd | bus.dm_wr) & ~bus.dm_done);
        check("strobe exclusive", bus.mem_rd & bus.mem_wr, 1'b0);
        if (bus.mem_wr) begin
          check("store mem_addr", bus.mem_addr, cur_dm_addr);
          check("store mem_wdata", bus.mem_wdata, cur_dm_wdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.dm_rd = 1'b0;
    bus.dm_wr = 1'b0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    do_reset();

    // Reset state
    smp();
    check("reset if_valid", bus.if_valid, 0);
    check("reset dm_done", bus.dm_done, 0);
    check("reset mem_rd", bus.mem_rd, 0);
    check("reset mem_wr", bus.mem_wr, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset if_rdata", bus.if_rdata, 0);
    check("reset dm_rdata", bus.dm_rdata, 0);
    check("reset conflict_cnt", bus.conflict_cnt, 0);
    check("reset timeout_err", bus.timeout_err, 0);
    next_cyc();

    // Lone fetch
    do_reset();
    force_en = 1'b1; force_val = 16'h1234; force_lat = 0;
    push_if(16'h1234, 1'b0);
    bus.if_addr = 16'h0040; bus.if_req = 1'b1;
    smp();
    check("lone c0 stall_fetch", bus.stall_fetch, 1);
    check("lone c0 mem_rd", bus.mem_rd, 0);
    next_cyc(); smp();
    check("lone c1 mem_rd", bus.mem_rd, 1);
    check("lone c1 mem_addr", bus.mem_addr, 16'h0040);
    check("lone c1 stall_fetch", bus.stall_fetch, 1);
    check("lone c1 if_valid", bus.if_valid, 0);
    next_cyc(); smp();
    check("lone c2 if_valid", bus.if_valid, 1);
    check("lone c2 if_rdata", bus.if_rdata, 16'h1234);
    check("lone c2 stall_fetch", bus.stall_fetch, 0);
    next_cyc(); bus.if_req = 1'b0; smp();
    check("lone c3 if_valid", bus.if_valid, 0);
    check("lone c3 mem_rd", bus.mem_rd, 0);

    // Simultaneous fetch and load
    do_reset();
    force_en = 1'b1; force_val = 16'hBEEF; force_lat = 0;
    push_dm(16'hBEEF, 1'b0);
    push_if(16'hBEEF, 1'b0);
    bus.if_addr = 16'h0040; bus.if_req = 1'b1;
    set_dm(1'b1, 1'b0, 16'h0100, 16'h0);
    smp();
    next_cyc(); smp();
    check("simul c1 mem_addr", bus.mem_addr, 16'h0100);
    check("simul c1 mem_rd", bus.mem_rd, 1);
    next_cyc(); smp();
    check("simul c2 dm_done", bus.dm_done, 1);
    check("simul c2 no bubble mem_rd", bus.mem_rd, 1);
    check("simul c2 fetch mem_addr", bus.mem_addr, 16'h0040);
    next_cyc(); set_dm(1'b0, 1'b0, 16'h0100, 16'h0); smp();
    check("simul c3 if_valid", bus.if_valid, 1);
    check("simul c3 conflict_cnt", bus.conflict_cnt, 1);
    next_cyc(); bus.if_req = 1'b0; smp();
    check("simul c4 conflict_cnt", bus.conflict_cnt, 1);

    // Store with wait states after a preload
    do_reset();
    force_en = 1'b1; force_val = 16'h5A5A; force_lat = 0;
    push_dm(16'h5A5A, 1'b0);
    set_dm(1'b1, 1'b0, 16'h0010, 16'h0);
    wait_pulse(1'b1, "preload");
    next_cyc();
    force_lat = 3;
    push_dm(16'h5A5A, 1'b0);
    set_dm(1'b0, 1'b1, 16'h0200, 16'h00AA);
    wbits = '0; rbits = '0; dbits = '0;
    for (int i = 0; i < 10; i++) begin
      smp();
      wbits[i] = bus.mem_wr; rbits[i] = bus.mem_rd; dbits[i] = bus.dm_done;
      next_cyc();
      if (dbits[i]) set_dm(1'b0, 1'b0, 16'h0200, 16'h00AA);
    end
    check("store mem_wr cycles", wbits, 15'h001E);
    check("store mem_rd cycles", rbits, 15'h0000);
    check("store dm_done cycles", dbits, 15'h0020);
    smp();
    check("store dm_rdata kept", bus.dm_rdata, 16'h5A5A);

    // Timeout on a load
    do_reset();
    force_lat = 99;
    push_dm(16'hFFFF, 1'b1);
    set_dm(1'b1, 1'b0, 16'h0300, 16'h0);
    rbits = '0; dbits = '0;
    for (int i = 0; i < 8; i++) begin
      smp();
      rbits[i] = bus.mem_rd; dbits[i] = bus.dm_done;
      next_cyc();
      if (dbits[i]) set_dm(1'b0, 1'b0, 16'h0300, 16'h0);
    end
    check("timeout mem_rd cycles", rbits, 15'h001E);
    check("timeout dm_done cycles", dbits, 15'h0020);
    smp();
    check("timeout dm_rdata", bus.dm_rdata, 16'hFFFF);
    check("timeout_err set", bus.timeout_err, 1);
    repeat (3) next_cyc();
    smp();
    check("timeout_err sticky", bus.timeout_err, 1);
    next_cyc();
    do_reset();
    smp();
    check("timeout_err cleared by reset", bus.timeout_err, 0);
    next_cyc();

    // Held fetch request
    do_reset();
    force_en = 1'b1; force_val = 16'h7777; force_lat = 0;
    for (int i = 0; i < 5; i++) push_if(16'h7777, 1'b0);
    bus.if_addr = 16'h0080; bus.if_req = 1'b1;
    vbits = '0; rbits = '0;
    for (int i = 0; i < 15; i++) begin
      smp();
      vbits[i] = bus.if_valid; rbits[i] = bus.mem_rd;
      next_cyc();
    end
    bus.if_req = 1'b0;
    check("held if_valid cycles", vbits, 15'h4924);
    check("held mem_rd cycles", rbits, 15'h2492);
    smp();
    check("held final mem_rd", bus.mem_rd, 0);
    check("held scoreboard drained", if_q.size(), 0);

    // Reset in the middle of a data access
    do_reset();
    force_lat = 99;
    bus.if_addr = 16'h0050; bus.if_req = 1'b1;
    set_dm(1'b1, 1'b0, 16'h0400, 16'h0);
    smp();
    next_cyc(); smp();
    check("rstmid c1 mem_rd", bus.mem_rd, 1);
    next_cyc(); smp();
    check("rstmid c2 conflict_cnt", bus.conflict_cnt, 1);
    next_cyc(); reset = 1'b1; smp();
    next_cyc(); smp();
    check("rstmid mem_rd", bus.mem_rd, 0);
    check("rstmid mem_addr", bus.mem_addr, 0);
    check("rstmid dm_done", bus.dm_done, 0);
    check("rstmid conflict_cnt", bus.conflict_cnt, 0);
    check("rstmid timeout_err", bus.timeout_err, 0);
    next_cyc();
    reset = 1'b0; bus.if_req = 1'b0; set_dm(1'b0, 1'b0, 16'h0400, 16'h0);
    for (int i = 0; i < 3; i++) begin
      smp();
      check("rstmid no dm_done", bus.dm_done, 0);
      next_cyc();
    end

    // Randomized concurrent traffic
    do_reset();
    fork
      run_fetch(40);
      run_data(40);
    join
    repeat (3) next_cyc();
    check("random fetch scoreboard drained", if_q.size(), 0);
    check("random data scoreboard drained", dm_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
